// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-stage program counter.
//   pc_state_t  - fetch FSM state encoding
//   HALT_OPCODE - opcode that stops fetch (shared with the decoder)
package pc_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } pc_state_t;

    localparam logic [6:0] HALT_OPCODE = 7'h7F;

endpackage

// File: rtl/pc_fetch_unit_sat_counter.sv
// sat_counter: enable-driven counter that sticks at all-ones.
//   clk      in   clock
//   rst      in   synchronous active-low reset (clears count)
//   i_en     in   count one event this cycle
//   o_count  out  current count (registered)
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] r_count;

    // Increment on enable unless already saturated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage program counter with redirect bubble, halt/resume,
// misaligned-redirect fault and a saturating count of sequential fetches.
//   clk, rst      clock; synchronous active-low reset
//   opcode        opcode at pc (only meaningful while fetch_valid)
//   stall         hold pc
//   redir_valid   redirect request, destination redir_target
//   resume        leave HALTED
//   pc            current fetch address (registered)
//   pc_plus       pc + 2**STEP_LOG2, wrapping (combinational)
//   fetch_valid   instruction at pc is valid (RUN)
//   halted/fault  HALTED / FAULT state flags
//   fetch_cnt     saturating count of sequentially accepted instructions
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter int unsigned       STEP_LOG2 = 0,
    parameter logic [WIDTH-1:0]  RESET_VEC = '0,
    parameter logic [6:0]        HALT_OP   = HALT_OPCODE,
    parameter int unsigned       CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 stall,
    input  logic                 redir_valid,
    input  logic [WIDTH-1:0]     redir_target,
    input  logic                 resume,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     pc_plus,
    output logic                 fetch_valid,
    output logic                 halted,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] fetch_cnt
);

    localparam logic [WIDTH-1:0] STEP       = WIDTH'(64'd1 << STEP_LOG2);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << STEP_LOG2) - 64'd1);

    pc_state_t        r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_fetch_valid;
    logic             r_halted;
    logic             r_fault;

    logic [WIDTH-1:0] w_pc_plus;
    logic             w_misaligned;
    logic             w_cnt_en;

    assign w_pc_plus    = r_pc + STEP;
    // Mask is all-zero for word addressing, so no target can be misaligned.
    assign w_misaligned = |(redir_target & ALIGN_MASK);
    // Only the plain sequential-advance row of RUN counts as an accepted fetch.
    assign w_cnt_en     = (r_state == ST_RUN) && !redir_valid &&
                          (opcode != HALT_OP) && !stall;

    // Fetch FSM; flag outputs are registered alongside each transition.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_VEC;
            r_fetch_valid <= 1'b1;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN, ST_BUBBLE: begin
                    if (redir_valid && w_misaligned) begin
                        r_state       <= ST_FAULT;
                        r_fetch_valid <= 1'b0;
                        r_fault       <= 1'b1;
                    end else if (redir_valid) begin
                        // Redirect wins over halt: a halt opcode here is wrong-path.
                        r_pc          <= redir_target;
                        r_state       <= ST_BUBBLE;
                        r_fetch_valid <= 1'b0;
                    end else if (r_state == ST_BUBBLE) begin
                        r_state       <= ST_RUN;
                        r_fetch_valid <= 1'b1;
                    end else if (opcode == HALT_OP) begin
                        r_state       <= ST_HALTED;
                        r_fetch_valid <= 1'b0;
                        r_halted      <= 1'b1;
                    end else if (!stall) begin
                        r_pc <= w_pc_plus;
                    end
                end
                ST_HALTED: begin
                    // Resume steps past the halt instruction.
                    if (resume) begin
                        r_pc          <= w_pc_plus;
                        r_state       <= ST_RUN;
                        r_fetch_valid <= 1'b1;
                        r_halted      <= 1'b0;
                    end
                end
                default: begin
                    // FAULT is sticky until reset.
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fetch_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_cnt_en),
        .o_count (fetch_cnt)
    );

    assign pc          = r_pc;
    assign pc_plus     = w_pc_plus;
    assign fetch_valid = r_fetch_valid;
    assign halted      = r_halted;
    assign fault       = r_fault;

endmodule
